// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes / InvSubBytes engine.
// LANES S-box lanes per beat, 16/LANES beats per 128-bit state.

module sub_bytes_iter_lane (
    input  logic [7:0] a_i,
    input  logic       inv_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte, so offset uses the inverted index.
    logic [10:0] ofs;

    // Table lookup selected by mode.
    always_comb begin
        ofs = {~a_i, 3'b000};
        y_o = inv_i ? INV[ofs +: 8] : FWD[ofs +: 8];
    end
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);
    localparam int NBEATS = 16 / LANES;
    localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LW = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 &&
        LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    src_q, src_d;
    logic            mode_q, mode_d;
    logic [127:0]    out_q, out_d;
    logic            accept;
    int              base;
    logic [LW-1:0]   lane_in;
    logic [LW-1:0]   lane_out;

    assign accept  = in_valid & in_ready;
    assign base    = int'(cnt_q) * LW;
    assign lane_in = src_q[base +: LW];
    assign out     = out_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sub_bytes_iter_lane u_lane (
            .a_i   (lane_in[8*j +: 8]),
            .inv_i (mode_q),
            .y_o   (lane_out[8*j +: 8])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE can hand straight over to a new job.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (cnt_q == LAST) state_d = DONE;
            DONE: begin
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            RUN: begin
                in_ready = 1'b0;
            end
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath next values: latch on accept, fill one slice per beat.
    always_comb begin
        src_d  = src_q;
        mode_d = mode_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        if (accept) begin
            src_d  = in;
            mode_d = inv;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            out_d[base +: LW] = lane_out;
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            src_q  <= '0;
            mode_q <= 1'b0;
            out_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            src_q  <= src_d;
            mode_q <= mode_d;
            out_q  <= out_d;
        end
    end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed bench for sub_bytes_iter.
// Five instances cover LANES = 1, 2, 4, 8, 16; index 2 is LANES=4.

module tb_sub_bytes_iter;
    localparam int N = 5;
    localparam int M = 2;
    localparam logic [127:0] V_IN  = 128'h003C6E471F4E22740E081B3154590B1A;
    localparam logic [127:0] V_OUT = 128'h63EB9FA0C02F9392AB30AFC720CB2BA2;
    localparam logic [127:0] P     = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PO    = 128'h638293C31BFC33F5C4EEACEA4BC12816;
    localparam logic [127:0] S63   = {16{8'h63}};
    localparam logic [127:0] ROW0  = 128'h76ABD7FE2B670130C56F6BF27B777C63;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         inv;
    logic         out_ready;
    logic [127:0] din  [N];
    logic         rdy  [N];
    logic         ov   [N];
    logic         bsy  [N];
    logic [127:0] dout [N];
    logic [127:0] res  [N];
    int           lat  [N];
    int           checks = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .in        (din[g]),
            .inv       (inv),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out       (dout[g]),
            .busy      (bsy[g])
        );
    end

    task automatic set_all(input logic [127:0] d);
        for (int g = 0; g < N; g++) din[g] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One job on every instance; records first out_valid cycle and data.
    task automatic run_all(input logic m, input bit rst);
        bit got [N];
        if (rst) do_reset();
        for (int g = 0; g < N; g++) begin
            got[g] = 1'b0;
            lat[g] = 0;
            res[g] = '0;
        end
        @(posedge clk); #1;
        inv = m;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inv = ~m;
        for (int g = 0; g < N; g++) din[g] = ~din[g];
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < N; g++) begin
                if (!got[g] && ov[g] === 1'b1) begin
                    got[g] = 1'b1;
                    lat[g] = k;
                    res[g] = dout[g];
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        inv = 1'b0;
        set_all('0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov[M] !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got=%0b want=0", ov[M]);
        end
        checks++;
        if (dout[M] !== 128'h0) begin
            fails++;
            $display("FAIL reset_out got=%h want=0", dout[M]);
        end
        checks++;
        if (bsy[M] !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got=%0b want=0", bsy[M]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy[M] !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%0b want=1", rdy[M]);
        end
    endtask

    task automatic test_fwd_vector();
        set_all(V_IN);
        run_all(1'b0, 1'b1);
        checks++;
        if (res[M] !== V_OUT) begin
            fails++;
            $display("FAIL fwd_vector got=%h want=%h", res[M], V_OUT);
        end
        checks++;
        if (lat[M] != 4) begin
            fails++;
            $display("FAIL fwd_latency got=%0d want=4", lat[M]);
        end
    endtask

    task automatic test_inv_vector();
        set_all(V_OUT);
        run_all(1'b1, 1'b1);
        checks++;
        if (res[M] !== V_IN) begin
            fails++;
            $display("FAIL inv_vector got=%h want=%h", res[M], V_IN);
        end
        set_all('0);
        run_all(1'b0, 1'b1);
        checks++;
        if (res[M] !== S63) begin
            fails++;
            $display("FAIL fwd_zeros got=%h want=%h", res[M], S63);
        end
        set_all(S63);
        run_all(1'b1, 1'b1);
        checks++;
        if (res[M] !== 128'h0) begin
            fails++;
            $display("FAIL inv_63s got=%h want=0", res[M]);
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        out_ready = 1'b0;
        set_all(V_IN);
        inv = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_all(P);
        inv = 1'b1;
        k = 0;
        while (ov[M] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k != 4) begin
            fails++;
            $display("FAIL bp_latency got=%0d want=4", k);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ov[M] !== 1'b1) begin
                fails++;
                $display("FAIL bp_valid c%0d got=%0b want=1", i, ov[M]);
            end
            checks++;
            if (dout[M] !== V_OUT) begin
                fails++;
                $display("FAIL bp_data c%0d got=%h want=%h", i, dout[M], V_OUT);
            end
            checks++;
            if (rdy[M] !== 1'b0) begin
                fails++;
                $display("FAIL bp_in_ready c%0d got=%0b want=0", i, rdy[M]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[M] !== 1'b0) begin
            fails++;
            $display("FAIL bp_release_valid got=%0b want=0", ov[M]);
        end
        checks++;
        if (bsy[M] !== 1'b0) begin
            fails++;
            $display("FAIL bp_release_busy got=%0b want=0", bsy[M]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [3];
        logic         md [3];
        logic [127:0] ex [3];
        logic [127:0] gv [3];
        int           gc [3];
        int           n_in;
        int           n_out;
        int           cyc;
        bit           acc;
        st[0] = V_IN;  md[0] = 1'b0; ex[0] = V_OUT;
        st[1] = V_OUT; md[1] = 1'b1; ex[1] = V_IN;
        st[2] = P;     md[2] = 1'b0; ex[2] = PO;
        n_in = 0;
        n_out = 0;
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            gv[i] = '0;
            gc[i] = 0;
        end
        do_reset();
        set_all(st[0]);
        inv = md[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (cyc < 40) begin
            if (ov[M] === 1'b1 && n_out < 3) begin
                gv[n_out] = dout[M];
                gc[n_out] = cyc;
                n_out++;
            end
            acc = in_valid && (rdy[M] === 1'b1);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                n_in++;
                if (n_in < 3) begin
                    set_all(st[n_in]);
                    inv = md[n_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (n_out != 3) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=3", n_out);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gv[i] !== ex[i]) begin
                fails++;
                $display("FAIL b2b_data%0d got=%h want=%h", i, gv[i], ex[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gc[i+1] - gc[i] != 5) begin
                fails++;
                $display("FAIL b2b_gap%0d got=%0d want=5", i, gc[i+1] - gc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        do_reset();
        set_all(V_IN);
        inv = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[M] !== 1'b0) begin
            fails++;
            $display("FAIL abort_valid got=%0b want=0", ov[M]);
        end
        checks++;
        if (dout[M] !== 128'h0) begin
            fails++;
            $display("FAIL abort_out got=%h want=0", dout[M]);
        end
        checks++;
        if (bsy[M] !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy got=%0b want=0", bsy[M]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy[M] !== 1'b1) begin
            fails++;
            $display("FAIL abort_in_ready got=%0b want=1", rdy[M]);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[M] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL abort_spurious_valid got=1 want=0");
        end
        set_all(V_OUT);
        run_all(1'b1, 1'b0);
        checks++;
        if (res[M] !== V_IN) begin
            fails++;
            $display("FAIL abort_next_job got=%h want=%h", res[M], V_IN);
        end
    endtask

    task automatic test_sweep();
        set_all(V_IN);
        run_all(1'b0, 1'b1);
        for (int g = 0; g < N; g++) begin
            checks++;
            if (res[g] !== V_OUT) begin
                fails++;
                $display("FAIL sweep_data L%0d got=%h want=%h", 1 << g, res[g], V_OUT);
            end
            checks++;
            if (lat[g] != (16 >> g)) begin
                fails++;
                $display("FAIL sweep_latency L%0d got=%0d want=%0d", 1 << g, lat[g], 16 >> g);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] pat;
        logic [127:0] fw [N];
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 16; k++) pat[8*k +: 8] = 8'(16 * c + k);
            set_all(pat);
            run_all(1'b0, 1'b1);
            for (int g = 0; g < N; g++) fw[g] = res[g];
            if (c == 0) begin
                for (int g = 0; g < N; g++) begin
                    checks++;
                    if (fw[g] !== ROW0) begin
                        fails++;
                        $display("FAIL rt_row0 L%0d got=%h want=%h", 1 << g, fw[g], ROW0);
                    end
                end
            end
            for (int g = 0; g < N; g++) din[g] = fw[g];
            run_all(1'b1, 1'b1);
            for (int g = 0; g < N; g++) begin
                checks++;
                if (res[g] !== pat) begin
                    fails++;
                    $display("FAIL rt L%0d chunk%0d got=%h want=%h", 1 << g, c, res[g], pat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_vector();
        test_inv_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
